// File: rtl/fifo_word_reader.sv
// Drains a byte-wide FIFO (one-cycle read latency) and packs the bytes big-endian
// into 32-bit words with byte strobes, presented on a valid/ready handshake.
module fifo_word_reader #(
  parameter int LENGTH_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [LENGTH_BITS-1:0] length,
  output logic                   busy,
  output logic                   done,
  input  logic                   fifo_empty,
  output logic                   fifo_read,
  input  logic [7:0]             fifo_rdata,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [31:0]            word_data,
  output logic [3:0]             word_strobe
);

  typedef enum logic [1:0] {IDLE, FETCH, OUTPUT} state_t;

  state_t                 state, state_next;
  logic [LENGTH_BITS-1:0] remaining;
  logic [2:0]             issued, captured, target;
  logic                   rd_pending;
  logic                   capture_last, handshake, last_word;
  logic [1:0]             lane;
  logic [4:0]             lane_lsb;
  logic [3:0]             strobe_next;

  // Bytes in the current word: four, or whatever is left of the transfer.
  assign target = (remaining >= LENGTH_BITS'(4)) ? 3'd4 : remaining[2:0];

  assign fifo_read    = reset_n && (state == FETCH) && !fifo_empty && (issued < target);
  assign capture_last = rd_pending && ((captured + 3'd1) == target);
  assign handshake    = (state == OUTPUT) && word_ready;
  assign last_word    = (remaining == LENGTH_BITS'(target));
  assign busy         = (state != IDLE);
  assign word_valid   = (state == OUTPUT);

  // First byte of a word lands in lane 3 ([31:24]).
  assign lane     = 2'd3 - captured[1:0];
  assign lane_lsb = {lane, 3'b000};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    strobe_next = 4'b0000;
    case (target)
      3'd4:    strobe_next = 4'b1111;
      3'd3:    strobe_next = 4'b1110;
      3'd2:    strobe_next = 4'b1100;
      3'd1:    strobe_next = 4'b1000;
      default: strobe_next = 4'b0000;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && (length != '0)) state_next = FETCH;
      FETCH:   if (capture_last) state_next = OUTPUT;
      OUTPUT:  if (handshake) state_next = last_word ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // The word register is reset too: downstream sees a defined zero word after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining   <= '0;
      issued      <= '0;
      captured    <= '0;
      rd_pending  <= 1'b0;
      done        <= 1'b0;
      word_data   <= '0;
      word_strobe <= '0;
    end else begin
      done       <= 1'b0;
      rd_pending <= fifo_read;
      if (fifo_read) issued <= issued + 3'd1;
      if (rd_pending) begin
        word_data[lane_lsb +: 8] <= fifo_rdata;
        captured                 <= captured + 3'd1;
        if (capture_last) word_strobe <= strobe_next;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) done <= 1'b1;
            else              remaining <= length;
          end
        end
        OUTPUT: begin
          if (handshake) begin
            remaining   <= remaining - LENGTH_BITS'(target);
            issued      <= '0;
            captured    <= '0;
            word_data   <= '0;
            word_strobe <= '0;
            if (last_word) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Bench for fifo_word_reader: FIFO model, table-driven transfers, corner sequences
// and randomized transfers against a byte-list packing model.
module tb_fifo_word_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] length = '0;
  logic        busy, done, fifo_read, word_valid;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rdata = '0;
  logic        word_ready = 1'b0;
  logic [31:0] word_data;
  logic [3:0]  word_strobe;

  fifo_word_reader #(.LENGTH_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .length(length),
    .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .fifo_rdata(fifo_rdata), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_strobe(word_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // FIFO model: read pops on the edge, data appears the cycle after.
  logic [7:0] feed_q[$];
  logic [7:0] fifo_q[$];
  always @(posedge clk) begin
    if (fifo_read && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
    while (feed_q.size() > 0) fifo_q.push_back(feed_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor, sampled mid-cycle.
  logic [35:0] got_q[$];
  int rd_cnt = 0, done_cnt = 0, valid_cnt = 0;
  int empty_err = 0, stab_err = 0, out_rd_err = 0, done_busy_err = 0;
  bit prev_hold = 1'b0;
  logic [35:0] prev_word = '0;
  always @(negedge clk) begin
    if (!reset_n) prev_hold = 1'b0;
    else begin
      if (fifo_read) rd_cnt++;
      if (fifo_read && fifo_empty) empty_err++;
      if (fifo_read && word_valid) out_rd_err++;
      if (word_valid) valid_cnt++;
      if (word_valid && word_ready) got_q.push_back({word_data, word_strobe});
      if (done) begin
        done_cnt++;
        if (busy) done_busy_err++;
      end
      if (prev_hold && (!word_valid || {word_data, word_strobe} != prev_word)) stab_err++;
      prev_hold = word_valid && !word_ready;
      prev_word = {word_data, word_strobe};
    end
  end

  task automatic clear_stats();
    rd_cnt = 0; done_cnt = 0; valid_cnt = 0;
    got_q.delete();
  endtask

  task automatic push_seq(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) feed_q.push_back(base + 8'(i));
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1;
    length = 16'(len);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    check({name, "_done_seen"}, done_cnt > 0, 1);
  endtask

  // Reference: chunk the byte stream into big-endian words, zero-padded.
  logic [7:0]  bytes_q[$];
  logic [35:0] exp_q[$];
  task automatic build_expected(input int len);
    logic [31:0] d;
    logic [3:0]  s;
    exp_q.delete();
    for (int w = 0; w * 4 < len; w++) begin
      d = '0;
      s = '0;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k < len) begin
          d[31 - 8 * k -: 8] = bytes_q[w * 4 + k];
          s[3 - k] = 1'b1;
        end
      end
      exp_q.push_back({d, s});
    end
  endtask

  typedef struct {
    int          len;
    logic [7:0]  base;
    int          nwords;
    logic [35:0] first;
    logic [35:0] last;
  } vec_t;
  vec_t vecs[6];

  int len;
  bit fin;

  initial begin
    vecs[0] = '{8, 8'h01, 2, {32'h01020304, 4'hF}, {32'h05060708, 4'hF}};
    vecs[1] = '{6, 8'h01, 2, {32'h01020304, 4'hF}, {32'h05060000, 4'hC}};
    vecs[2] = '{1, 8'h11, 1, {32'h11000000, 4'h8}, {32'h11000000, 4'h8}};
    vecs[3] = '{3, 8'h20, 1, {32'h20212200, 4'hE}, {32'h20212200, 4'hE}};
    vecs[4] = '{5, 8'h30, 2, {32'h30313233, 4'hF}, {32'h34000000, 4'h8}};
    vecs[5] = '{2, 8'h40, 1, {32'h40410000, 4'hC}, {32'h40410000, 4'hC}};

    // Reset state
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", word_valid, 0);
    check("rst_read", fifo_read, 0);
    check("rst_word", {word_data, word_strobe}, 0);
    reset_n = 1'b1;
    tick(2);

    // Table-driven transfers with word_ready held high
    word_ready = 1'b1;
    foreach (vecs[v]) begin
      clear_stats();
      push_seq(vecs[v].len, vecs[v].base);
      pulse_start(vecs[v].len);
      wait_done($sformatf("vec%0d", v));
      tick(3);
      check($sformatf("vec%0d_nwords", v), got_q.size(), vecs[v].nwords);
      if (got_q.size() == vecs[v].nwords) begin
        check($sformatf("vec%0d_first", v), got_q[0], vecs[v].first);
        check($sformatf("vec%0d_last", v), got_q[vecs[v].nwords - 1], vecs[v].last);
      end
      check($sformatf("vec%0d_reads", v), rd_cnt, vecs[v].len);
      check($sformatf("vec%0d_done_once", v), done_cnt, 1);
      check($sformatf("vec%0d_fifo_left", v), fifo_q.size(), 0);
      check($sformatf("vec%0d_busy_after", v), busy, 0);
    end

    // Slow feed: one byte every 3 cycles
    clear_stats();
    pulse_start(4);
    for (int i = 0; i < 4; i++) begin
      feed_q.push_back(8'(i + 1));
      tick(3);
    end
    wait_done("slow");
    tick(2);
    check("slow_nwords", got_q.size(), 1);
    if (got_q.size() == 1) check("slow_word", got_q[0], {32'h01020304, 4'hF});
    check("slow_reads", rd_cnt, 4);

    // Downstream stall for 10 cycles on the first word
    clear_stats();
    word_ready = 1'b0;
    push_seq(8, 8'h01);
    pulse_start(8);
    for (int c = 0; c < 50 && valid_cnt == 0; c++) tick(1);
    check("stall_valid_seen", valid_cnt > 0, 1);
    tick(10);
    check("stall_word", {word_data, word_strobe}, {32'h01020304, 4'hF});
    check("stall_reads_held", rd_cnt, 4);
    word_ready = 1'b1;
    wait_done("stall");
    tick(2);
    check("stall_nwords", got_q.size(), 2);
    if (got_q.size() == 2) check("stall_second", got_q[1], {32'h05060708, 4'hF});

    // Zero length: done the cycle after, nothing else
    clear_stats();
    start = 1'b1;
    length = '0;
    tick(1);
    start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    tick(5);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_reads", rd_cnt, 0);
    check("zero_valid", valid_cnt, 0);

    // Start while busy is ignored
    clear_stats();
    push_seq(8, 8'h50);
    pulse_start(4);
    tick(2);
    pulse_start(8);
    wait_done("ignore");
    tick(4);
    check("ignore_nwords", got_q.size(), 1);
    if (got_q.size() == 1) check("ignore_word", got_q[0], {32'h50515253, 4'hF});
    check("ignore_reads", rd_cnt, 4);
    check("ignore_done_cnt", done_cnt, 1);
    fifo_q.delete();

    // Reset mid-transfer after two reads
    clear_stats();
    push_seq(4, 8'h01);
    pulse_start(4);
    for (int c = 0; c < 50 && rd_cnt < 2; c++) tick(1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", word_valid, 0);
    check("abort_read", fifo_read, 0);
    check("abort_done", done, 0);
    tick(2);
    fifo_q.delete();
    reset_n = 1'b1;
    tick(3);
    check("abort_no_done", done_cnt, 0);
    clear_stats();
    feed_q.push_back(8'hAA); feed_q.push_back(8'hBB);
    feed_q.push_back(8'hCC); feed_q.push_back(8'hDD);
    pulse_start(4);
    wait_done("restart");
    tick(2);
    check("restart_nwords", got_q.size(), 1);
    if (got_q.size() == 1) check("restart_word", got_q[0], {32'hAABBCCDD, 4'hF});

    // Randomized transfers against the packing model
    for (int t = 0; t < 25; t++) begin
      clear_stats();
      word_ready = 1'b0;
      len = $urandom_range(0, 13);
      bytes_q.delete();
      for (int i = 0; i < len; i++) bytes_q.push_back(8'($urandom));
      build_expected(len);
      fin = 1'b0;
      pulse_start(len);
      fork
        begin
          for (int i = 0; i < len; i++) begin
            tick($urandom_range(0, 2));
            feed_q.push_back(bytes_q[i]);
          end
        end
        begin
          wait_done($sformatf("rnd%0d", t));
          fin = 1'b1;
        end
        begin
          while (!fin) begin
            word_ready = 1'($urandom_range(0, 1));
            tick(1);
          end
        end
      join
      word_ready = 1'b0;
      tick(2);
      check($sformatf("rnd%0d_nwords", t), got_q.size(), exp_q.size());
      if (got_q.size() == exp_q.size())
        foreach (exp_q[w]) check($sformatf("rnd%0d_word%0d", t, w), got_q[w], exp_q[w]);
      check($sformatf("rnd%0d_reads", t), rd_cnt, len);
      check($sformatf("rnd%0d_done_cnt", t), done_cnt, 1);
    end

    // Properties accumulated by the monitor over the whole run
    check("read_while_empty", empty_err, 0);
    check("read_in_output", out_rd_err, 0);
    check("word_stability", stab_err, 0);
    check("busy_with_done", done_busy_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
